// File: rtl/hex_uart_pkg.sv
// Shared types and constants for the hex UART monitor: serializer states,
// line terminators, report length and the nibble-to-ASCII mapping.
package hex_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [2:0] REPORT_LEN = 3'd6;

    // 0-9 -> '0'..'9', A-F -> 'A'..'F' (0x37 + 10 = 0x41)
    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            hex_ascii = 8'h30 + {4'h0, nibble};
        end else begin
            hex_ascii = 8'h37 + {4'h0, nibble};
        end
    endfunction

endpackage

// File: rtl/hex_uart_monitor_if.sv
// Byte handshake between the character sequencer and the byte serializer.
interface hex_uart_monitor_if;

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);

endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer. Ready is raised in IDLE and on the last cycle of a stop
// bit, so a waiting byte starts with no idle gap between characters.
module uart_byte_tx
    import hex_uart_pkg::*;
#(
    parameter int BIT_CLKS = 434
) (
    input  logic                     clk,
    input  logic                     reset,
    hex_uart_monitor_if.slave        bus,
    output logic                     txd
);

    localparam logic [15:0] BIT_LAST = 16'(BIT_CLKS - 1);

    tx_state_t   state_reg, state_next;
    logic [15:0] bit_cnt_reg, bit_cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shift_reg, shift_next;
    logic        txd_reg, txd_next;
    logic        bit_end;
    logic        ready;
    logic        accept;

    assign bit_end        = (bit_cnt_reg == BIT_LAST);
    assign ready          = (state_reg == IDLE) || ((state_reg == STOP) && bit_end);
    assign accept         = bus.byte_valid && ready;
    assign bus.byte_ready = ready;
    assign txd            = txd_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            txd_reg     <= 1'b1;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            txd_reg     <= txd_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = ((state_reg == IDLE) || bit_end) ? 16'd0 : bit_cnt_reg + 16'd1;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        txd_next     = txd_reg;
        if (accept) begin
            state_next   = START;
            bit_cnt_next = 16'd0;
            shift_next   = bus.byte_data;
            txd_next     = 1'b0;
        end else begin
            case (state_reg)
                IDLE: txd_next = 1'b1;
                START: begin
                    if (bit_end) begin
                        state_next   = DATA;
                        bit_idx_next = 3'd0;
                        txd_next     = shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_reg == 3'd7) begin
                            state_next = STOP;
                            txd_next   = 1'b1;
                        end else begin
                            // shift_reg[1] becomes the next bit after the shift
                            bit_idx_next = bit_idx_reg + 3'd1;
                            shift_next   = {1'b0, shift_reg[7:1]};
                            txd_next     = shift_reg[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hex_uart_monitor.sv
// Reports a 16-bit word over UART as four hex digits plus CR LF. The word is
// snapshotted on the accepting edge so later changes do not corrupt a report.
module hex_uart_monitor
    import hex_uart_pkg::*;
#(
    parameter int BIT_CLKS = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        trigger,
    output logic        busy,
    output logic        done,
    output logic        txd
);

    hex_uart_monitor_if byte_bus ();

    logic [15:0] snap_reg, snap_next;
    logic [2:0]  char_idx_reg, char_idx_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic [2:0]  next_idx;
    logic [3:0]  snap_nib [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nib
            assign snap_nib[gi] = snap_reg[4*gi +: 4];
        end
    endgenerate

    uart_byte_tx #(.BIT_CLKS(BIT_CLKS)) u_byte_tx (
        .clk   (clk),
        .reset (reset),
        .bus   (byte_bus),
        .txd   (txd)
    );

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign next_idx = char_idx_reg + 3'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_reg     <= '0;
            char_idx_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            snap_reg     <= snap_next;
            char_idx_reg <= char_idx_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        snap_next           = snap_reg;
        char_idx_next       = char_idx_reg;
        busy_next           = busy_reg;
        done_next           = 1'b0;
        byte_bus.byte_valid = 1'b0;
        byte_bus.byte_data  = hex_ascii(value[15:12]);
        if (!busy_reg) begin
            // First digit comes straight from value: the snapshot loads on this same edge
            byte_bus.byte_valid = trigger;
            if (trigger && byte_bus.byte_ready) begin
                busy_next     = 1'b1;
                snap_next     = value;
                char_idx_next = 3'd0;
            end
        end else if (char_idx_reg == REPORT_LEN - 3'd1) begin
            if (byte_bus.byte_ready) begin
                busy_next     = 1'b0;
                done_next     = 1'b1;
                char_idx_next = 3'd0;
            end
        end else begin
            byte_bus.byte_valid = 1'b1;
            case (next_idx)
                3'd4:    byte_bus.byte_data = ASCII_CR;
                3'd5:    byte_bus.byte_data = ASCII_LF;
                default: byte_bus.byte_data = hex_ascii(snap_nib[2'd3 - next_idx[1:0]]);
            endcase
            if (byte_bus.byte_ready) begin
                char_idx_next = next_idx;
            end
        end
    end

endmodule

// File: tb/tb_hex_uart_monitor.sv
// Scoreboard bench: stimulus queues expected characters, a UART decoder pops
// and compares each received byte; busy/done timing is checked alongside.
module tb_hex_uart_monitor;

    localparam int B  = 4;
    localparam int BT = 434;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        trigger;
    logic        busy, done, txd;
    logic [15:0] value_t;
    logic        trigger_t;
    logic        busy_t, done_t, txd_t;

    always #5 clk = ~clk;

    hex_uart_monitor #(.BIT_CLKS(B)) dut (
        .clk(clk), .reset(reset), .value(value), .trigger(trigger),
        .busy(busy), .done(done), .txd(txd)
    );

    hex_uart_monitor #(.BIT_CLKS(BT)) dut_t (
        .clk(clk), .reset(reset), .value(value_t), .trigger(trigger_t),
        .busy(busy_t), .done(done_t), .txd(txd_t)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // UART decoder / scoreboard monitor: samples mid-bit on falling edges
    int         dec_cnt    = 0;
    int         dec_bit    = 0;
    logic       dec_active = 1'b0;
    logic [7:0] dec_byte   = 8'h00;
    logic [7:0] dec_exp;

    always @(negedge clk) begin
        if (!reset) begin
            dec_active = 1'b0;
        end else if (!dec_active) begin
            if (txd == 1'b0) begin
                dec_active = 1'b1;
                dec_cnt    = B / 2;
                dec_bit    = -1;
            end
        end else begin
            dec_cnt--;
            if (dec_cnt == 0) begin
                if (dec_bit == -1) begin
                    check("start bit", 32'(txd), 32'd0);
                    dec_bit = 0;
                    dec_cnt = B;
                end else if (dec_bit < 8) begin
                    dec_byte[dec_bit] = txd;
                    dec_bit++;
                    dec_cnt = B;
                end else begin
                    check("stop bit", 32'(txd), 32'd1);
                    dec_active = 1'b0;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected char: got %02h, expected none", dec_byte);
                    end else begin
                        dec_exp = exp_q.pop_front();
                        check("char", 32'(dec_byte), 32'(dec_exp));
                        $display("rx char %02h (expected %02h) at %0t", dec_byte, dec_exp, $time);
                    end
                end
            end
        end
    end

    // busy run length and done pulse counting
    int busy_run = 0, last_busy_run = 0, done_total = 0;

    always @(negedge clk) begin
        if (done) done_total++;
        if (busy) begin
            busy_run++;
        end else begin
            if (busy_run != 0) last_busy_run = busy_run;
            busy_run = 0;
        end
    end

    task automatic push_report(input logic [47:0] s);
        for (int i = 5; i >= 0; i--) exp_q.push_back(s[8*i +: 8]);
    endtask

    // Leaves the caller on the falling edge just after the accepting edge
    task automatic pulse_trigger(input logic [15:0] v);
        @(negedge clk);
        value   = v;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        check("busy on accept", 32'(busy), 32'd1);
        check("txd start on accept", 32'(txd), 32'd0);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL done timeout: got none after %0d cycles, expected a pulse", budget);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int busy_seen;
        int bad;
        logic [9:0] frame;

        reset     = 1'b0;
        trigger   = 1'b0;
        value     = 16'h0000;
        trigger_t = 1'b0;
        value_t   = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset txd", 32'(txd), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // basic report
        d0 = done_total;
        push_report(48'h31_41_33_46_0D_0A);
        pulse_trigger(16'h1A3F);
        wait_done(300);
        repeat (2) @(negedge clk);
        check("busy length 1A3F", 32'(last_busy_run), 32'd240);
        check("done pulses 1A3F", 32'(done_total - d0), 32'd1);

        // snapshot: value changes during the second character
        push_report(48'h42_45_45_46_0D_0A);
        pulse_trigger(16'hBEEF);
        repeat (50) @(negedge clk);
        value = 16'h0000;
        wait_done(300);
        repeat (2) @(negedge clk);

        // ignore trigger while busy
        d0 = done_total;
        push_report(48'h43_30_44_45_0D_0A);
        pulse_trigger(16'hC0DE);
        repeat (99) @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        wait_done(300);
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("no queued report", 32'(busy_seen), 32'd0);
        check("done pulses ignore", 32'(done_total - d0), 32'd1);

        // back-to-back with trigger held
        d0 = done_total;
        push_report(48'h30_30_30_39_0D_0A);
        push_report(48'h30_30_30_39_0D_0A);
        @(negedge clk);
        value   = 16'h0009;
        trigger = 1'b1;
        @(negedge clk);
        check("b2b first accept", 32'(busy), 32'd1);
        wait_done(300);
        check("b2b gap busy", 32'(busy), 32'd0);
        check("b2b gap txd", 32'(txd), 32'd1);
        @(negedge clk);
        check("b2b second busy", 32'(busy), 32'd1);
        check("b2b second start", 32'(txd), 32'd0);
        trigger = 1'b0;
        wait_done(300);
        repeat (2) @(negedge clk);
        check("b2b report length", 32'(last_busy_run), 32'd240);
        check("done pulses b2b", 32'(done_total - d0), 32'd2);

        // reset during a data bit of the third character
        d0 = done_total;
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h32);
        pulse_trigger(16'h1234);
        repeat (90) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("reset abort txd", 32'(txd), 32'd1);
        check("reset abort busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("reset abort done", 32'(done), 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        value   = 16'hFFFF;
        trigger = 1'b1;
        push_report(48'h46_46_46_46_0D_0A);
        @(negedge clk);
        check("accept after reset", 32'(busy), 32'd1);
        trigger = 1'b0;
        wait_done(300);
        repeat (2) @(negedge clk);
        check("done pulses reset", 32'(done_total - d0), 32'd1);
        check("queue drained", 32'(exp_q.size()), 32'd0);

        // exact bit timing at 434 clocks per bit, first char '5' = 0x35
        frame = {1'b1, 8'h35, 1'b0};
        @(negedge clk);
        value_t   = 16'h5000;
        trigger_t = 1'b1;
        @(negedge clk);
        trigger_t = 1'b0;
        check("timing busy", 32'(busy_t), 32'd1);
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int i = 0; i < BT; i++) begin
                if (txd_t !== frame[k]) bad++;
                @(negedge clk);
            end
            check($sformatf("bit %0d wrong cycles", k), 32'(bad), 32'd0);
            $display("timing bit %0d level %0b checked over %0d cycles", k, frame[k], BT);
        end
        check("timing next start", 32'(txd_t), 32'd0);
        check("timing no done", 32'(done_t), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hex_uart_monitor.md
HEX_UART_MONITOR -- requirements
Module: hex_uart_monitor

Interface
REQ-001 SHALL have parameter BIT_CLKS, default 434, meaning clk cycles per UART bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock, 50 MHz, all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port value  input  16  word to report, the same 16-bit value driven to the 7-segment decoder.
REQ-005 SHALL have port trigger  input  1  report request, level-sampled each cycle.
REQ-006 SHALL have port busy  output  1  high while a report is being transmitted.
REQ-007 SHALL have port done  output  1  one-cycle pulse at the end of a report.
REQ-008 SHALL have port txd  output  1  UART serial output, idle high, to UART_TXD.

Function
REQ-009 SHALL transmit each report as 6 characters: 4 uppercase ASCII hex digits of the captured value, MS nibble first, then 0x0D, then 0x0A.
REQ-010 SHALL map nibbles 0-9 to 0x30-0x39 and A-F to 0x41-0x46.
REQ-011 SHALL frame each character as 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit lasts exactly BIT_CLKS cycles.
REQ-012 SHALL send characters back-to-back with no idle gap, so a report lasts exactly 60*BIT_CLKS cycles.
REQ-013 SHALL capture value into an internal snapshot on the rising edge where trigger=1 and busy=0; busy and txd=0 (start of first bit) take effect on that same edge.
REQ-014 SHALL ignore value changes after capture; the report reflects the snapshot only.
REQ-015 SHALL ignore trigger while busy=1; the request is not queued.
REQ-016 SHALL use states IDLE, START, DATA, STOP: IDLE->START on accepted trigger; START->DATA after BIT_CLKS; DATA->STOP after 8 bits; STOP->START if characters remain, otherwise STOP->IDLE.
REQ-017 SHALL, on the STOP->IDLE edge, drop busy to 0 and drive done=1 for exactly one cycle.
REQ-018 SHALL accept a trigger held high through the done cycle on the first cycle busy=0, so back-to-back reports are separated by exactly one idle cycle with txd=1.
REQ-019 SHALL wrap the bit-time counter from BIT_CLKS-1 to 0; bit and character indices SHALL be 3-bit counters bounded to 0..7 and 0..5.

Reset
REQ-020 SHALL, while reset=0, force txd=1, busy=0, done=0, state IDLE, and all counters and the snapshot to 0, asynchronously.
REQ-021 SHALL, on reset assertion mid-frame, abort immediately with txd=1 and no partial stop bit or trailing characters; after release the block SHALL be idle and SHALL accept a new trigger on the first clock edge.

Structure
REQ-022 SHALL place the state enumeration, the ASCII constants CR=0x0D and LF=0x0A, and the report length 6 in a shared package hex_uart_pkg.
REQ-023 SHALL implement the byte serializer (START/DATA/STOP, bit timer, byte-valid/byte-ready handshake) as the sub-module uart_byte_tx; the top level SHALL sequence characters and generate the hex digits.

Verification
REQ-024 SHALL verify basic report: BIT_CLKS=4, value=0x1A3F, trigger for 1 cycle -> a UART decoder reads "1A3F\r\n" (0x31 0x41 0x33 0x46 0x0D 0x0A), busy high for exactly 240 cycles, done pulses once.
REQ-025 SHALL verify snapshot: value=0xBEEF at trigger, changed to 0x0000 during character 2 -> report is "BEEF\r\n".
REQ-026 SHALL verify ignore-while-busy: a second trigger pulse at cycle 100 of a report -> exactly one report and one done pulse.
REQ-027 SHALL verify back-to-back: trigger held high, value=0x0009 -> consecutive reports "0009\r\n" separated by exactly one cycle of txd=1 and busy=0.
REQ-028 SHALL verify reset mid-frame: reset=0 during a data bit of character 3 -> txd=1 and busy=0 within the same cycle; after release, trigger with value=0xFFFF -> a clean "FFFF\r\n".
REQ-029 SHALL verify timing: BIT_CLKS=434 -> each bit of the first character measures 434 cycles ±0.
